// File: rtl/seg7_monitor_if.sv
// Segment-bus bundle between a 7-segment display driver and its monitor.
// The master drives the segment lines and the flag clear; the slave (the
// monitor) returns the decoded digit, the tick period and the sticky flags.
interface seg7_monitor_if #(
    parameter int CNT_W = 24
);
    logic [6:0]       segments_in;
    logic             clear_flags;
    logic [3:0]       digit_out;
    logic             digit_valid;
    logic [CNT_W-1:0] period_out;
    logic             period_valid;
    logic             seq_error;
    logic             bad_pattern;

    modport master (
        output segments_in, clear_flags,
        input  digit_out, digit_valid, period_out, period_valid, seq_error, bad_pattern
    );

    modport slave (
        input  segments_in, clear_flags,
        output digit_out, digit_valid, period_out, period_valid, seq_error, bad_pattern
    );
endinterface

// File: rtl/seg7_monitor.sv
// 7-segment seconds-display observer: synchronizes and de-glitches the
// segment lines, decodes each accepted pattern to a BCD digit, checks that
// digits step 0..9..0 and measures clock cycles between digit changes.
module seg7_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 24
) (
    input  logic          clk,
    input  logic          reset,
    seg7_monitor_if.slave bus
);
    localparam logic [7:0]       STABLE_N = 8'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // {is_digit, digit}; blank and bad patterns both report is_digit = 0
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'h3F:   decode_seg = {1'b1, 4'd0};
            7'h06:   decode_seg = {1'b1, 4'd1};
            7'h5B:   decode_seg = {1'b1, 4'd2};
            7'h4F:   decode_seg = {1'b1, 4'd3};
            7'h66:   decode_seg = {1'b1, 4'd4};
            7'h6D:   decode_seg = {1'b1, 4'd5};
            7'h7D:   decode_seg = {1'b1, 4'd6};
            7'h07:   decode_seg = {1'b1, 4'd7};
            7'h7F:   decode_seg = {1'b1, 4'd8};
            7'h6F:   decode_seg = {1'b1, 4'd9};
            default: decode_seg = {1'b0, 4'd0};
        endcase
    endfunction

    function automatic logic [7:0] inc_stable(input logic [7:0] c);
        inc_stable = (c >= STABLE_N) ? STABLE_N : c + 8'd1;
    endfunction

    function automatic logic [CNT_W-1:0] inc_period(input logic [CNT_W-1:0] c);
        inc_period = (c == CNT_MAX) ? CNT_MAX : c + 1'b1;
    endfunction

    function automatic logic [3:0] next_digit(input logic [3:0] d);
        next_digit = (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    logic [6:0]       sync_p0, sync_p1;
    logic [6:0]       cand_p2, accepted;
    logic [7:0]       stable_cnt;
    logic [CNT_W-1:0] period_cnt;

    logic [6:0] cand_next;
    logic [7:0] cnt_next;
    logic       accept;
    logic       dec_is_digit;
    logic [3:0] dec_digit;
    logic       dec_is_blank;
    logic       seq_set, bad_set;

    logic [3:0]       digit_r;
    logic             digit_valid_r;
    logic [CNT_W-1:0] period_r;
    logic             period_valid_r;
    logic             seq_error_r, bad_pattern_r;

    // Two-flop synchronizer; only the second stage feeds the filter
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= 7'h00;
            sync_p1 <= 7'h00;
        end else begin
            sync_p0 <= bus.segments_in;
            sync_p1 <= sync_p0;
        end
    end

    // Next candidate/count; acceptance fires on the edge the count reaches the threshold
    always_comb begin
        cand_next = cand_p2;
        cnt_next  = inc_stable(stable_cnt);
        if (sync_p1 != cand_p2) begin
            cand_next = sync_p1;
            cnt_next  = 8'd1;
        end
        accept                    = (cnt_next == STABLE_N) && (cand_next != accepted);
        {dec_is_digit, dec_digit} = decode_seg(cand_next);
        dec_is_blank              = (cand_next == 7'h00);
        seq_set = accept && dec_is_digit && digit_valid_r && (dec_digit != next_digit(digit_r));
        bad_set = accept && !dec_is_digit && !dec_is_blank;
    end

    // Stability filter state and the accepted pattern
    always_ff @(posedge clk) begin
        if (reset) begin
            cand_p2    <= 7'h00;
            stable_cnt <= 8'd0;
            accepted   <= 7'h00;
        end else begin
            cand_p2    <= cand_next;
            stable_cnt <= cnt_next;
            if (accept)
                accepted <= cand_next;
        end
    end

    // Cycles since the last acceptance event, restarting at 1 on each event
    always_ff @(posedge clk) begin
        if (reset)
            period_cnt <= '0;
        else if (accept)
            period_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
        else
            period_cnt <= inc_period(period_cnt);
    end

    // Digit, period and sticky flag outputs; a flag set beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            digit_r        <= 4'd0;
            digit_valid_r  <= 1'b0;
            period_r       <= '0;
            period_valid_r <= 1'b0;
            seq_error_r    <= 1'b0;
            bad_pattern_r  <= 1'b0;
        end else begin
            period_valid_r <= 1'b0;
            if (accept) begin
                if (dec_is_digit) begin
                    digit_r       <= dec_digit;
                    digit_valid_r <= 1'b1;
                    if (digit_valid_r) begin
                        period_r       <= period_cnt;
                        period_valid_r <= 1'b1;
                    end
                end else begin
                    digit_valid_r <= 1'b0;
                end
            end
            seq_error_r   <= seq_set | (seq_error_r & ~bus.clear_flags);
            bad_pattern_r <= bad_set | (bad_pattern_r & ~bus.clear_flags);
        end
    end

    assign bus.digit_out    = digit_r;
    assign bus.digit_valid  = digit_valid_r;
    assign bus.period_out   = period_r;
    assign bus.period_valid = period_valid_r;
    assign bus.seq_error    = seq_error_r;
    assign bus.bad_pattern  = bad_pattern_r;
endmodule

// File: tb/tb_seg7_monitor.sv
// Bench for seg7_monitor: input is a list of (pattern, hold length) segments;
// a reference model turns each segment into an expected output event at a
// predicted cycle, and a negedge monitor pops and compares them.
module tb_seg7_monitor;
    localparam int STABLE = 4;
    localparam int CW     = 8;
    localparam int PMAX   = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    seg7_monitor_if #(.CNT_W(CW)) bus ();

    seg7_monitor #(.STABLE_CYCLES(STABLE), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int digit;
        bit dvalid;
        bit pvalid;
        int period;
        bit seq;
        bit bad;
    } rec_t;

    rec_t exp_q[$];
    rec_t cur;
    bit   started    = 1'b0;
    int   compared   = 0;
    int   mismatched = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // reference model state
    logic [6:0] m_acc;
    logic [6:0] drv_pat;
    int m_digit, m_period, m_last, last_n;
    bit m_valid, m_seq, m_bad;

    // 0..9 digit, 10 blank, -1 bad
    function automatic int ref_decode(input logic [6:0] p);
        if (p == 7'h00) return 10;
        for (int i = 0; i < 10; i++)
            if (seg_tab[i] == p) return i;
        return -1;
    endfunction

    task automatic push_rec(input int c, input bit pv);
        rec_t r;
        int idx;
        r.cyc = c; r.digit = m_digit; r.dvalid = m_valid; r.pvalid = pv;
        r.period = m_period; r.seq = m_seq; r.bad = m_bad;
        idx = exp_q.size();
        while (idx > 0 && exp_q[idx-1].cyc > c) idx--;
        exp_q.insert(idx, r);
    endtask

    task automatic model_reset();
        m_acc = 7'h00; m_digit = 0; m_period = 0; m_last = 0;
        m_valid = 1'b0; m_seq = 1'b0; m_bad = 1'b0;
    endtask

    task automatic reset_pulse();
        int c;
        reset = 1'b1;
        c = cyc + 1;
        while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc >= c) void'(exp_q.pop_back());
        model_reset();
        push_rec(c, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        last_n = 0;
    endtask

    task automatic clear_pulse();
        bus.clear_flags = 1'b1;
        m_seq = 1'b0; m_bad = 1'b0;
        push_rec(cyc + 1, 1'b0);
        @(posedge clk); #1;
        bus.clear_flags = 1'b0;
    endtask

    // Hold a pattern for n cycles; clr_evt pulses clear_flags on the event edge
    task automatic hold(input logic [6:0] pat, input int n, input bit clr_evt);
        int k, ecyc, d;
        bit pv, clr;
        k = cyc;
        bus.segments_in = pat;
        drv_pat = pat;
        ecyc = k + 2 + STABLE;
        pv = 1'b0;
        clr = 1'b0;
        if (n >= STABLE && pat != m_acc) begin
            clr = clr_evt && (n >= STABLE + 2);
            if (clr) begin m_seq = 1'b0; m_bad = 1'b0; end
            d = ref_decode(pat);
            if (d >= 0 && d <= 9) begin
                if (m_valid) begin
                    pv = 1'b1;
                    m_period = (ecyc - m_last > PMAX) ? PMAX : ecyc - m_last;
                    if (d != (m_digit + 1) % 10) m_seq = 1'b1;
                end
                m_digit = d;
                m_valid = 1'b1;
            end else if (d == 10) begin
                m_valid = 1'b0;
            end else begin
                m_valid = 1'b0;
                m_bad = 1'b1;
            end
            m_last = ecyc;
            m_acc = pat;
            push_rec(ecyc, pv);
        end
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.clear_flags = clr && (cyc == ecyc - 1);
        end
        last_n = n;
    endtask

    task automatic check(input string nm, input rec_t e);
        compared++;
        if (bus.digit_out !== 4'(e.digit) || bus.digit_valid !== e.dvalid ||
            bus.period_valid !== e.pvalid || bus.period_out !== CW'(e.period) ||
            bus.seq_error !== e.seq || bus.bad_pattern !== e.bad) begin
            mismatched++;
            $display("FAIL %s cyc=%0d got digit=%0d dv=%b pv=%b period=%0d seq=%b bad=%b want digit=%0d dv=%b pv=%b period=%0d seq=%b bad=%b",
                     nm, cyc, bus.digit_out, bus.digit_valid, bus.period_valid, bus.period_out,
                     bus.seq_error, bus.bad_pattern, e.digit, e.dvalid, e.pvalid, e.period, e.seq, e.bad);
        end
    endtask

    // Monitor: compare on predicted event cycles, otherwise outputs must hold
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            cur = exp_q.pop_front();
            check((cur.cyc == cyc) ? "event" : "late_event", cur);
            cur.pvalid = 1'b0;
            started = 1'b1;
        end else if (started) begin
            check("idle", cur);
        end
    end

    initial begin
        int r, s, n, wait_cnt;
        logic [6:0] pat;
        bus.segments_in = 7'h00;
        bus.clear_flags = 1'b0;
        drv_pat = 7'h00;
        last_n = 0;
        model_reset();
        reset_pulse();

        // clean count 0..9,0 at 100 cycles per digit
        for (int i = 0; i <= 10; i++) hold(seg_tab[i % 10], 100, 1'b0);

        // glitches: 3-cycle ignored, 4-cycle accepted, then out-of-order return
        hold(7'h06, 100, 1'b0);
        hold(7'h5B, 3, 1'b0);
        hold(7'h06, 50, 1'b0);
        hold(7'h5B, 4, 1'b0);
        hold(7'h06, 50, 1'b0);
        clear_pulse();

        // 3 -> 5 skip, clear, then error coincident with clear
        hold(7'h5B, 50, 1'b0);
        hold(7'h4F, 50, 1'b0);
        hold(7'h6D, 50, 1'b0);
        clear_pulse();
        hold(7'h66, 50, 1'b1);
        clear_pulse();

        // bad pattern, relock, blank
        hold(7'h55, 50, 1'b0);
        hold(7'h3F, 50, 1'b0);
        hold(7'h00, 50, 1'b0);
        clear_pulse();
        hold(7'h06, 50, 1'b0);

        // period saturation
        hold(7'h5B, 400, 1'b0);
        hold(7'h4F, 20, 1'b0);

        // reset while showing 7, then 8 relocks quietly
        hold(7'h66, 30, 1'b0);
        hold(7'h6D, 30, 1'b0);
        hold(7'h7D, 30, 1'b0);
        hold(7'h07, 30, 1'b0);
        reset_pulse();
        hold(7'h7F, 30, 1'b0);

        // randomized segments
        for (int it = 0; it < 150; it++) begin
            r = $urandom_range(0, 99);
            if (r < 4) reset_pulse();
            else if (r < 12 && last_n >= STABLE + 2) clear_pulse();
            s = $urandom_range(0, 9);
            if (s < 6 && m_valid) pat = seg_tab[(m_digit + 1) % 10];
            else if (s < 8)       pat = seg_tab[$urandom_range(0, 9)];
            else if (s == 8)      pat = 7'h00;
            else                  pat = 7'($urandom);
            while (pat == drv_pat) pat = 7'($urandom);
            s = $urandom_range(0, 9);
            if (s < 2)      n = $urandom_range(1, STABLE - 1);
            else if (s < 4) n = $urandom_range(STABLE, STABLE + 1);
            else if (s < 9) n = $urandom_range(STABLE + 2, 60);
            else            n = $urandom_range(260, 300);
            hold(pat, n, (n >= STABLE + 2) && ($urandom_range(0, 7) == 0));
        end
        hold(drv_pat ^ 7'h01, 20, 1'b0);

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 100) begin
            @(posedge clk);
            wait_cnt++;
        end
        @(negedge clk);
        #1;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/seg7_monitor.md
# seg7_monitor

Observer for a 7-segment seconds display. Samples the segment lines of a running display, synchronizes and de-glitches them, and decodes each stable pattern back to a BCD digit. Checks that digits advance 0→9→0 in order and measures the clock-cycle interval between digit changes. Sits on the board/test side of the segment bus, as the receiving end of the display driver, for self-check and tick-period measurement.

## Interface

- STABLE_CYCLES, 4: consecutive synchronized samples a new pattern must hold before acceptance (legal range 1–255)
- CNT_W, 24: width of the period counter and period_out

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- segments_in  in  7  asynchronous segment lines, bit0=a … bit6=g, active-high
- clear_flags  in  1  synchronous clear of sticky error flags
- digit_out  out  4  last accepted valid digit, 0–9
- digit_valid  out  1  high while the accepted pattern is a valid digit
- period_out  out  CNT_W  cycles between the last two accepted digit changes
- period_valid  out  1  one-cycle pulse when period_out updates
- seq_error  out  1  sticky: a digit arrived out of sequence
- bad_pattern  out  1  sticky: a non-digit, non-blank pattern was accepted

## Operation

- Decode table (gfedcba): 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F. 0x00 is blank. Every other value is bad.
- Synchronizer: two flops on segments_in, reset to 0x00. Only the second stage (sync) is used downstream.
- Filter: holds a candidate and a stability count.
  - If sync differs from the candidate, load the candidate and set the count to 1.
  - Otherwise increment the count, saturating at STABLE_CYCLES.
  - When the count reaches STABLE_CYCLES and the candidate differs from the accepted pattern, the candidate becomes accepted. That edge is an acceptance event.
  - Reset sets both the accepted pattern and the candidate to 0x00.
- On an acceptance event:
  - Valid digit d:
    - digit_out←d, digit_valid←1.
    - If digit_valid was already 1 (locked) and d ≠ (prev+1) mod 10, set seq_error.
    - If locked, period_out←period counter and pulse period_valid.
  - Blank: digit_valid←0. digit_out holds. No flag is set.
  - Bad: digit_valid←0, bad_pattern←1. digit_out holds.
  - Any event with digit_valid previously 0 gives no sequence check and no period output. This is the relock behaviour.
- Period counter:
  - Loads 1 on every acceptance event.
  - Otherwise increments each cycle, saturating at 2^CNT_W−1. A saturated value is reported as-is.
  - Resets to 0.
- Sticky flags: clear_flags clears seq_error and bad_pattern. If a set and a clear happen in the same cycle, the set wins.

## Timing

- Reset values: digit_out=0, digit_valid=0, period_out=0, period_valid=0, seq_error=0, bad_pattern=0, period counter=0.
- Latency: segments_in changes and stays stable before edge t. The acceptance event and the output update happen at edge t+1+STABLE_CYCLES. That is 6 edges for the default value.
- Glitch rejection:
  - A new pattern held for fewer than STABLE_CYCLES synchronized samples is ignored.
  - A glitch that returns to the accepted pattern causes no event.
- Period semantics: period_out equals the number of clk edges between two consecutive acceptance events. Equal input change spacing gives the same period, because the pipeline latency cancels.
- Flag timing: period_valid is high for exactly one cycle, concurrent with the digit_out update. seq_error and bad_pattern assert at the same edge.
- Reset mid-operation: all state returns to reset values at the next edge. The first digit after reset never produces period_valid or seq_error.
- Throughput: at most one acceptance event per STABLE_CYCLES cycles.

## Test plan

- Clean count, STABLE_CYCLES=4: drive 0x3F, 0x06, … 0x6F, 0x3F, each held for 100 cycles.
  - digit_out runs 0..9,0. Each digit appears 6 edges after its input change.
  - period_valid pulses 10 times with period_out=100.
  - seq_error stays 0.
- Glitch: with 0x06 accepted, drive 0x5B for 3 cycles and then back to 0x06.
  - No event, no period_valid, digit_out stays 1.
  - A 4-cycle 0x5B is accepted as 2. Returning to 0x06 then sets seq_error.
- Sequence error and clear: step 3→5.
  - seq_error=1 and period_valid pulses.
  - clear_flags for 1 cycle gives seq_error=0.
  - clear_flags asserted in the same cycle as a new error leaves seq_error=1.
- Bad and blank patterns: drive 0x55.
  - bad_pattern=1, digit_valid=0, digit_out holds.
  - Next, 0x3F is accepted with no period_valid and no seq_error (relock).
  - Blank 0x00 drops digit_valid without setting bad_pattern.
- Saturation, CNT_W=8: hold a digit for 400 cycles, then advance.
  - period_out=255 with a period_valid pulse.
- Reset mid-count: assert reset while digit_out=7.
  - All outputs are 0 on the next edge.
  - The following digit 8 gives digit_valid=1, no seq_error, no period_valid.
